// File: rtl/game_pkg.sv
// Shared types and constants for the player motion engine.
package game_pkg;

    typedef enum logic [2:0] {
        GROUND,
        AIR,
        DEAD,
        WIN,
        OVER
    } state_t;

    localparam int PLAYER_W = 16;
    localparam int PLAYER_H = 16;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Adds a signed 6-bit velocity to a 10-bit position in 11-bit signed math.
    function automatic logic signed [10:0] pos_add(input logic [9:0] pos,
                                                   input logic signed [5:0] vel);
        return $signed({1'b0, pos}) + $signed({{5{vel[5]}}, vel});
    endfunction

endpackage

// File: rtl/jump_edge_latch.sv
// Turns a held jump button into a one-shot request that lives until the next frame.
module jump_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn_jump,
    output logic jump_req
);

    logic btn_prev;

    // Latch a press; a press landing on the tick clock survives into the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= 1'b0;
            jump_req <= 1'b0;
        end else begin
            btn_prev <= btn_jump;
            if (btn_jump && !btn_prev)
                jump_req <= 1'b1;
            else if (frame_tick)
                jump_req <= 1'b0;
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player physics: walking, jumping, gravity, landing, death, goal and lives.
module player_motion_ctrl
    import game_pkg::*;
#(
    parameter int SPAWN_X        = 20,
    parameter int SPAWN_Y        = 344,
    parameter int WALK_SPEED     = 2,
    parameter int JUMP_VEL       = 9,
    parameter int GRAVITY        = 1,
    parameter int MAX_FALL       = 8,
    parameter int X_MAX          = 623,
    parameter int FALL_LIMIT     = 464,
    parameter int RESPAWN_FRAMES = 60,
    parameter int START_LIVES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic [1:0] level,
    input  logic       on_ground,
    input  logic [9:0] support_y,
    input  logic       hit_ceiling,
    input  logic       hit_left_wall,
    input  logic       hit_right_wall,
    input  logic       at_goal_region,
    input  logic       in_lava,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       facing_left,
    output logic [1:0] lives,
    output logic       level_done,
    output logic       death,
    output logic       game_over
);

    localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic [9:0]        SPAWN_X_V = 10'(SPAWN_X);
    localparam logic [9:0]        SPAWN_Y_V = 10'(SPAWN_Y);
    localparam logic signed [10:0] WALK_V   = 11'(WALK_SPEED);
    localparam logic signed [10:0] X_MAX_V  = 11'(X_MAX);
    localparam logic signed [10:0] FALL_V   = 11'(FALL_LIMIT);
    localparam logic signed [10:0] HEIGHT_V = 11'(PLAYER_H);
    localparam logic signed [5:0]  JUMP_V   = 6'(JUMP_VEL);
    localparam logic signed [5:0]  GRAV_V   = 6'(GRAVITY);
    localparam logic signed [5:0]  MAXF_V   = 6'(MAX_FALL);
    localparam logic [1:0]         LIVES_V  = 2'(START_LIVES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);

    state_t                  state, state_n;
    logic signed [5:0]       vy, vy_n, vy_t, vy_g;
    logic [9:0]              x_n, y_n, x_mv, land_y, fall_y, jump_y;
    logic signed [10:0]      dx, x_sum, land_sum, fall_sum, jump_sum;
    logic                    face_n, face_mv, jump_req;
    logic [1:0]              lives_n, lvl_q, lvl_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    death_n, done_n, die, spawn;

    jump_edge_latch u_jump (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_jump   (btn_jump),
        .jump_req   (jump_req)
    );

    // Candidate motion for this frame, independent of the current state.
    always_comb begin
        dx      = '0;
        face_mv = facing_left;
        if (btn_right && !btn_left) begin
            face_mv = 1'b0;
            if (!hit_right_wall) dx = WALK_V;
        end else if (btn_left && !btn_right) begin
            face_mv = 1'b1;
            if (!hit_left_wall) dx = -WALK_V;
        end
        x_sum = $signed({1'b0, player_x}) + dx;
        if (x_sum < 0)            x_mv = '0;
        else if (x_sum > X_MAX_V) x_mv = X_MAX_V[9:0];
        else                      x_mv = x_sum[9:0];

        land_sum = $signed({1'b0, support_y}) - HEIGHT_V;
        land_y   = (land_sum < 0) ? '0 : land_sum[9:0];
        jump_sum = pos_add(player_y, -JUMP_V);
        jump_y   = (jump_sum < 0) ? '0 : jump_sum[9:0];

        vy_t     = (hit_ceiling && vy < 0) ? '0 : vy;
        vy_g     = ((vy_t + GRAV_V) > MAXF_V) ? MAXF_V : (vy_t + GRAV_V);
        fall_sum = pos_add(player_y, vy_g);
        fall_y   = (fall_sum < 0) ? '0 : fall_sum[9:0];
    end

    // Next-state and datapath update, evaluated only on a frame tick.
    always_comb begin
        state_n = state;
        x_n     = player_x;
        y_n     = player_y;
        vy_n    = vy;
        lives_n = lives;
        cnt_n   = cnt;
        lvl_n   = lvl_q;
        face_n  = facing_left;
        death_n = 1'b0;
        done_n  = 1'b0;
        die     = 1'b0;
        spawn   = 1'b0;
        if (frame_tick) begin
            case (state)
                GROUND: begin
                    if (in_lava) begin
                        die = 1'b1;
                    end else if (at_goal_region) begin
                        state_n = WIN;
                        done_n  = 1'b1;
                        lvl_n   = level;
                    end else begin
                        x_n    = x_mv;
                        face_n = face_mv;
                        if (jump_req && on_ground) begin
                            vy_n    = (jump_sum < 0) ? '0 : -JUMP_V;
                            y_n     = jump_y;
                            state_n = AIR;
                        end else if (!on_ground) begin
                            vy_n    = '0;
                            state_n = AIR;
                        end else begin
                            y_n = land_y;
                        end
                    end
                end
                AIR: begin
                    x_n    = x_mv;
                    face_n = face_mv;
                    if (on_ground && !vy_t[5]) begin
                        y_n     = land_y;
                        vy_n    = '0;
                        state_n = GROUND;
                    end else begin
                        vy_n = (fall_sum < 0) ? '0 : vy_g;
                        y_n  = fall_y;
                        if (in_lava || fall_sum >= FALL_V) die = 1'b1;
                    end
                end
                DEAD: begin
                    if (cnt == CNT_LAST) spawn = 1'b1;
                    else                 cnt_n = cnt + 1'b1;
                end
                WIN: begin
                    if (level != lvl_q) spawn = 1'b1;
                end
                default: ;
            endcase
        end
        if (die) begin
            death_n = 1'b1;
            lives_n = (lives == 2'd0) ? 2'd0 : lives - 1'b1;
            cnt_n   = '0;
            state_n = (lives_n == 2'd0) ? OVER : DEAD;
        end
        if (spawn) begin
            x_n     = SPAWN_X_V;
            y_n     = SPAWN_Y_V;
            vy_n    = '0;
            state_n = GROUND;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= GROUND;
        else       state <= state_n;
    end

    // Position, velocity, lives, counters and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            player_x    <= SPAWN_X_V;
            player_y    <= SPAWN_Y_V;
            vy          <= '0;
            lives       <= LIVES_V;
            cnt         <= '0;
            lvl_q       <= '0;
            facing_left <= 1'b0;
            death       <= 1'b0;
            level_done  <= 1'b0;
        end else begin
            player_x    <= x_n;
            player_y    <= y_n;
            vy          <= vy_n;
            lives       <= lives_n;
            cnt         <= cnt_n;
            lvl_q       <= lvl_n;
            facing_left <= face_n;
            death       <= death_n;
            level_done  <= done_n;
        end
    end

    // Game-over level follows the terminal state.
    always_comb begin
        game_over = (state == OVER);
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: directed scenarios plus randomized frames
// compared against an integer behavioural model of the motion rules.
module tb_player_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame_tick, btn_left, btn_right, btn_jump;
    logic [1:0] level;
    logic       on_ground, hit_ceiling, hit_left_wall, hit_right_wall, at_goal_region, in_lava;
    logic [9:0] support_y;
    logic [9:0] player_x, player_y;
    logic       facing_left, level_done, death, game_over;
    logic [1:0] lives;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int    m_x, m_y, m_vy, m_lives, m_dead_ticks, m_lvl;
    string m_mode;
    bit    m_face, m_jreq, m_prev, m_death, m_done;

    always #5 clk = ~clk;

    player_motion_ctrl #(.SPAWN_X(20), .SPAWN_Y(344), .RESPAWN_FRAMES(60), .START_LIVES(3)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .level(level), .on_ground(on_ground), .support_y(support_y),
        .hit_ceiling(hit_ceiling), .hit_left_wall(hit_left_wall), .hit_right_wall(hit_right_wall),
        .at_goal_region(at_goal_region), .in_lava(in_lava),
        .player_x(player_x), .player_y(player_y), .facing_left(facing_left),
        .lives(lives), .level_done(level_done), .death(death), .game_over(game_over)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic model_reset();
        m_x = 20; m_y = 344; m_vy = 0; m_lives = 3; m_dead_ticks = 0; m_lvl = 0;
        m_mode = "GROUND"; m_face = 0; m_jreq = 0; m_prev = 0; m_death = 0; m_done = 0;
    endtask

    task automatic model_walk();
        int dir;
        dir = (btn_right && !btn_left) ? 1 : ((btn_left && !btn_right) ? -1 : 0);
        if (dir != 0) m_face = (dir < 0);
        if ((dir > 0 && hit_right_wall) || (dir < 0 && hit_left_wall)) dir = 0;
        m_x = m_x + 2 * dir;
        if (m_x < 0) m_x = 0;
        if (m_x > 623) m_x = 623;
    endtask

    task automatic model_die();
        m_death = 1;
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) m_mode = "OVER";
        else begin m_mode = "DEAD"; m_dead_ticks = 0; end
    endtask

    task automatic model_spawn();
        m_x = 20; m_y = 344; m_vy = 0; m_mode = "GROUND";
    endtask

    task automatic model_tick();
        int v, ground_y;
        ground_y = (int'(support_y) >= 16) ? int'(support_y) - 16 : 0;
        if (m_mode == "GROUND") begin
            if (in_lava) model_die();
            else if (at_goal_region) begin m_mode = "WIN"; m_done = 1; m_lvl = level; end
            else begin
                model_walk();
                if (m_jreq && on_ground) begin
                    m_vy = -9; m_y = m_y - 9;
                    if (m_y < 0) begin m_y = 0; m_vy = 0; end
                    m_mode = "AIR";
                end else if (!on_ground) begin
                    m_vy = 0; m_mode = "AIR";
                end else m_y = ground_y;
            end
        end else if (m_mode == "AIR") begin
            model_walk();
            v = (hit_ceiling && m_vy < 0) ? 0 : m_vy;
            if (on_ground && v >= 0) begin
                m_y = ground_y; m_vy = 0; m_mode = "GROUND";
            end else begin
                m_vy = (v + 1 > 8) ? 8 : v + 1;
                m_y = m_y + m_vy;
                if (m_y < 0) begin m_y = 0; m_vy = 0; end
                if (in_lava || m_y >= 464) model_die();
            end
        end else if (m_mode == "DEAD") begin
            m_dead_ticks++;
            if (m_dead_ticks == 60) model_spawn();
        end else if (m_mode == "WIN") begin
            if (int'(level) != m_lvl) model_spawn();
        end
    endtask

    // One clock; inputs are already stable, the model sees the same edge as the DUT.
    task automatic step(input bit tick);
        bit rise;
        frame_tick = tick;
        @(posedge clk);
        if (reset) model_reset();
        else begin
            m_death = 0; m_done = 0;
            if (tick) model_tick();
            rise = btn_jump && !m_prev;
            if (tick) m_jreq = rise;
            else if (rise) m_jreq = 1;
            m_prev = btn_jump;
        end
        #1;
        frame_tick = 0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin step(1); step(0); end
    endtask

    task automatic clear_inputs();
        btn_left = 0; btn_right = 0; btn_jump = 0; level = 0;
        on_ground = 1; support_y = 10'd360; hit_ceiling = 0;
        hit_left_wall = 0; hit_right_wall = 0; at_goal_region = 0; in_lava = 0;
    endtask

    task automatic do_reset();
        reset = 1; step(0); step(0); reset = 0;
    endtask

    task automatic test_reset();
        bit saw;
        clear_inputs(); do_reset();
        checks++; if (player_x !== 10'd20) begin errors++; $display("FAIL reset_x: got %0d want 20", player_x); end
        checks++; if (player_y !== 10'd344) begin errors++; $display("FAIL reset_y: got %0d want 344", player_y); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", lives); end
        checks++; if ({game_over, facing_left, death, level_done} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {game_over, facing_left, death, level_done}); end
        saw = 0;
        for (int i = 0; i < 10; i++) begin step(1); saw |= (death | level_done); step(0); end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", saw); end
        checks++; if ({player_x, player_y} !== {10'd20, 10'd344}) begin errors++; $display("FAIL idle_pos: got %0d,%0d want 20,344", player_x, player_y); end
    endtask

    task automatic test_walk();
        clear_inputs(); do_reset();
        btn_right = 1; tick_n(5);
        checks++; if (player_x !== 10'd30) begin errors++; $display("FAIL walk_right: got %0d want 30", player_x); end
        hit_right_wall = 1; tick_n(3);
        checks++; if (player_x !== 10'd30) begin errors++; $display("FAIL right_wall: got %0d want 30", player_x); end
        btn_right = 0; hit_right_wall = 0; btn_left = 1; tick_n(1);
        checks++; if (player_x !== 10'd28 || facing_left !== 1'b1) begin errors++; $display("FAIL walk_left: got x=%0d face=%0d want x=28 face=1", player_x, facing_left); end
        btn_right = 1; tick_n(2);
        checks++; if (player_x !== 10'd28 || facing_left !== 1'b1) begin errors++; $display("FAIL both_btns: got x=%0d face=%0d want x=28 face=1", player_x, facing_left); end
        btn_right = 0; tick_n(15);
        checks++; if (player_x !== 10'd0) begin errors++; $display("FAIL clamp_left: got %0d want 0", player_x); end
        btn_left = 0; btn_right = 1; tick_n(320);
        checks++; if (player_x !== 10'd623 || facing_left !== 1'b0) begin errors++; $display("FAIL clamp_right: got x=%0d face=%0d want x=623 face=0", player_x, facing_left); end
        btn_right = 0;
    endtask

    task automatic test_jump();
        clear_inputs(); do_reset();
        tick_n(2);
        btn_jump = 1; step(0);
        step(1);
        checks++; if (player_y !== 10'd335) begin errors++; $display("FAIL jump_1: got %0d want 335", player_y); end
        on_ground = 0; step(1);
        checks++; if (player_y !== 10'd327) begin errors++; $display("FAIL jump_2: got %0d want 327", player_y); end
        step(1);
        checks++; if (player_y !== 10'd320) begin errors++; $display("FAIL jump_3: got %0d want 320", player_y); end
        tick_n(7);
        checks++; if (player_y !== 10'd299) begin errors++; $display("FAIL apex: got %0d want 299", player_y); end
        on_ground = 1; support_y = 10'd300; step(1);
        checks++; if (player_y !== 10'd284) begin errors++; $display("FAIL land: got %0d want 284", player_y); end
        tick_n(3);
        checks++; if (player_y !== 10'd284) begin errors++; $display("FAIL held_no_rejump: got %0d want 284", player_y); end
        btn_jump = 0; step(0); btn_jump = 1; step(0);
        step(1);
        checks++; if (player_y !== 10'd275) begin errors++; $display("FAIL rejump: got %0d want 275", player_y); end
        on_ground = 0; hit_ceiling = 1; step(1);
        checks++; if (player_y !== 10'd276) begin errors++; $display("FAIL ceiling: got %0d want 276", player_y); end
        clear_inputs();
    endtask

    task automatic test_death();
        clear_inputs(); do_reset();
        on_ground = 0; step(1);
        in_lava = 1; step(1);
        checks++; if (death !== 1'b1 || lives !== 2'd2 || player_y !== 10'd345) begin errors++; $display("FAIL lava_death: got death=%0d lives=%0d y=%0d want 1,2,345", death, lives, player_y); end
        in_lava = 0; on_ground = 1; step(0);
        checks++; if (death !== 1'b0) begin errors++; $display("FAIL death_pulse_width: got %0d want 0", death); end
        tick_n(59);
        checks++; if ({player_x, player_y} !== {10'd20, 10'd345}) begin errors++; $display("FAIL dead_frozen: got %0d,%0d want 20,345", player_x, player_y); end
        step(1);
        checks++; if ({player_x, player_y} !== {10'd20, 10'd344}) begin errors++; $display("FAIL respawn: got %0d,%0d want 20,344", player_x, player_y); end
        support_y = 10'd350; tick_n(1);
        checks++; if (player_y !== 10'd334 || lives !== 2'd2) begin errors++; $display("FAIL respawn_ground: got y=%0d lives=%0d want 334,2", player_y, lives); end
        on_ground = 0; step(1); in_lava = 1; step(1); in_lava = 0; tick_n(5);
        do_reset();
        checks++; if (lives !== 2'd3 || {player_x, player_y} !== {10'd20, 10'd344} || death !== 1'b0) begin errors++; $display("FAIL reset_mid_dead: got lives=%0d x=%0d y=%0d want 3,20,344", lives, player_x, player_y); end
        on_ground = 1; support_y = 10'd350; tick_n(1);
        checks++; if (player_y !== 10'd334) begin errors++; $display("FAIL reset_mid_dead_ground: got %0d want 334", player_y); end
        clear_inputs();
    endtask

    task automatic test_game_over();
        int n;
        clear_inputs(); do_reset();
        on_ground = 0; step(1); in_lava = 1; step(1); in_lava = 0; on_ground = 1;
        tick_n(60);
        on_ground = 0; n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1); n++;
            if (death) break;
        end
        checks++; if (n !== 20 || player_y !== 10'd468 || lives !== 2'd1) begin errors++; $display("FAIL fall_death: got ticks=%0d y=%0d lives=%0d want 20,468,1", n, player_y, lives); end
        on_ground = 1; tick_n(60);
        on_ground = 0; step(1); in_lava = 1; step(1);
        checks++; if (game_over !== 1'b1 || lives !== 2'd0 || death !== 1'b1) begin errors++; $display("FAIL game_over: got go=%0d lives=%0d death=%0d want 1,0,1", game_over, lives, death); end
        in_lava = 0; btn_right = 1; level = 2'd3; on_ground = 1;
        for (int i = 0; i < 10; i++) begin btn_jump = ~btn_jump; step(0); step(1); end
        checks++; if ({player_x, player_y} !== {10'd20, 10'd345} || lives !== 2'd0 || game_over !== 1'b1 || death !== 1'b0) begin errors++; $display("FAIL over_frozen: got x=%0d y=%0d lives=%0d go=%0d want 20,345,0,1", player_x, player_y, lives, game_over); end
        clear_inputs(); do_reset();
        checks++; if (game_over !== 1'b0 || lives !== 2'd3) begin errors++; $display("FAIL over_reset: got go=%0d lives=%0d want 0,3", game_over, lives); end
    endtask

    task automatic test_goal();
        bit saw;
        clear_inputs(); do_reset();
        btn_right = 1; tick_n(5); btn_right = 0;
        at_goal_region = 1; step(1);
        checks++; if (level_done !== 1'b1) begin errors++; $display("FAIL level_done: got %0d want 1", level_done); end
        step(0);
        checks++; if (level_done !== 1'b0) begin errors++; $display("FAIL level_done_width: got %0d want 0", level_done); end
        at_goal_region = 0; btn_right = 1; saw = 0;
        for (int i = 0; i < 5; i++) begin step(1); saw |= level_done; step(0); end
        checks++; if (player_x !== 10'd30 || saw !== 1'b0) begin errors++; $display("FAIL win_frozen: got x=%0d pulse=%0d want 30,0", player_x, saw); end
        level = 2'd1; step(1);
        checks++; if ({player_x, player_y} !== {10'd20, 10'd344} || lives !== 2'd3) begin errors++; $display("FAIL next_level: got x=%0d y=%0d lives=%0d want 20,344,3", player_x, player_y, lives); end
        step(1); level = 2'd2; step(1);
        checks++; if (player_x !== 10'd24) begin errors++; $display("FAIL level_change_ignored: got %0d want 24", player_x); end
        btn_right = 1; tick_n(1);
        reset = 1; at_goal_region = 1; step(1); reset = 0; at_goal_region = 0;
        checks++; if (player_x !== 10'd20 || level_done !== 1'b0) begin errors++; $display("FAIL reset_beats_tick: got x=%0d done=%0d want 20,0", player_x, level_done); end
        clear_inputs();
    endtask

    task automatic test_random();
        clear_inputs(); do_reset();
        for (int i = 0; i < 600; i++) begin
            btn_jump = ($urandom_range(0, 2) == 0);
            step(0);
            btn_left       = ($urandom_range(0, 2) == 0);
            btn_right      = ($urandom_range(0, 2) == 0);
            on_ground      = ($urandom_range(0, 9) < 6);
            support_y      = 10'($urandom_range(0, 479));
            hit_ceiling    = ($urandom_range(0, 9) == 0);
            hit_left_wall  = ($urandom_range(0, 9) == 0);
            hit_right_wall = ($urandom_range(0, 9) == 0);
            at_goal_region = ($urandom_range(0, 39) == 0);
            in_lava        = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) level = 2'($urandom_range(0, 3));
            step(1);
            checks++; if (int'(player_x) != m_x) begin errors++; $display("FAIL rnd_x[%0d]: got %0d want %0d", i, player_x, m_x); end
            checks++; if (int'(player_y) != m_y) begin errors++; $display("FAIL rnd_y[%0d]: got %0d want %0d", i, player_y, m_y); end
            checks++; if (int'(lives) != m_lives) begin errors++; $display("FAIL rnd_lives[%0d]: got %0d want %0d", i, lives, m_lives); end
            checks++; if (facing_left !== m_face) begin errors++; $display("FAIL rnd_face[%0d]: got %0d want %0d", i, facing_left, m_face); end
            checks++; if ({death, level_done} !== {m_death, m_done}) begin errors++; $display("FAIL rnd_pulses[%0d]: got %b want %b", i, {death, level_done}, {m_death, m_done}); end
            checks++; if (game_over !== (m_mode == "OVER")) begin errors++; $display("FAIL rnd_over[%0d]: got %0d want %0d", i, game_over, m_mode == "OVER"); end
            if (m_mode == "OVER" && $urandom_range(0, 4) == 0) do_reset();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1; frame_tick = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_walk();
        test_jump();
        test_death();
        test_game_over();
        test_goal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
